// File: rtl/dc_settle_monitor_pkg.sv
// Shared types, default parameters and helpers for the DC settle monitor.
// Optional peak-to-peak ripple rejection is enabled by DC_SETTLE_PKPK_EN.
package dc_settle_pkg;

  localparam int unsigned DATA_W   = 12;
  localparam int unsigned WIN_LOG2 = 4;
  localparam int unsigned TOL      = 2;
  localparam int unsigned STABLE_N = 2;
  localparam int unsigned MAX_WIN  = 64;

  localparam int unsigned ACC_W  = DATA_W + WIN_LOG2;
  localparam int unsigned WCNT_W = $clog2(MAX_WIN + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    EVAL,
    DONE
  } state_e;

  function automatic int unsigned absdiff(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/dc_settle_monitor_if.sv
// Valid/ready sample stream feeding the DC settle monitor.
interface dc_settle_monitor_if #(
  parameter int unsigned DATA_W = 12
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/dc_settle_monitor_window_avg.sv
// Window accumulator: sums 2^WIN_LOG2 accepted samples and exposes their mean.
// With DC_SETTLE_PKPK_EN it also tracks the window min/max spread.
module dc_window_avg
  import dc_settle_pkg::*;
#(
  parameter int unsigned DATA_W   = dc_settle_pkg::DATA_W,
  parameter int unsigned WIN_LOG2 = dc_settle_pkg::WIN_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_fire,
  input  logic [DATA_W-1:0] in_data,
  output logic              win_last,
  output logic [DATA_W-1:0] avg
`ifdef DC_SETTLE_PKPK_EN
  ,
  output logic [DATA_W-1:0] pkpk
`endif
);

  localparam int unsigned AW = DATA_W + WIN_LOG2;

  logic [AW-1:0]       acc_q, acc_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (in_fire) begin
      acc_d = acc_q + AW'(in_data);
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // Sample counter wraps to zero on the last sample, so it is ready for the next window.
  assign win_last = in_fire && (cnt_q == '1);
  assign avg      = acc_q[AW-1:WIN_LOG2];

`ifdef DC_SETTLE_PKPK_EN
  logic [DATA_W-1:0] min_q, min_d, max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (in_fire) begin
      if (cnt_q == '0) begin
        min_d = in_data;
        max_d = in_data;
      end else begin
        if (in_data < min_q) min_d = in_data;
        if (in_data > max_q) max_d = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign pkpk = max_q - min_q;
`endif

endmodule

// File: rtl/dc_settle_monitor.sv
// DC settle monitor: compares successive window averages and reports settled/timeout.
// DC_SETTLE_PKPK_EN adds the pkpk output and ripple rejection in the stability test.
module dc_settle_monitor
  import dc_settle_pkg::*;
#(
  parameter int unsigned DATA_W   = dc_settle_pkg::DATA_W,
  parameter int unsigned WIN_LOG2 = dc_settle_pkg::WIN_LOG2,
  parameter int unsigned TOL      = dc_settle_pkg::TOL,
  parameter int unsigned STABLE_N = dc_settle_pkg::STABLE_N,
  parameter int unsigned MAX_WIN  = dc_settle_pkg::MAX_WIN,
  localparam int unsigned WCNT_BITS = $clog2(MAX_WIN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  dc_settle_monitor_if.slave   s,
  output logic                 busy,
  output logic                 done,
  output logic                 settled,
  output logic                 timeout,
  output logic [DATA_W-1:0]    result,
  output logic [WCNT_BITS-1:0] win_count
`ifdef DC_SETTLE_PKPK_EN
  ,
  output logic [DATA_W-1:0]    pkpk
`endif
);

  localparam int unsigned SB = $clog2(STABLE_N + 1);

  state_e            state_q, state_d;
  logic              settled_q, settled_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [WCNT_BITS-1:0] wcnt_q, wcnt_d;
  logic [SB-1:0]     stable_q, stable_d;
  logic              first_q, first_d;

  logic              clear, fire, rdy, win_last, ok;
  logic [DATA_W-1:0] avg, diff;

`ifdef DC_SETTLE_PKPK_EN
  logic [DATA_W-1:0] win_pkpk, pkpk_q, pkpk_d;
`endif

  dc_window_avg #(
    .DATA_W  (DATA_W),
    .WIN_LOG2(WIN_LOG2)
  ) u_avg (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .in_fire (fire),
    .in_data (s.s_data),
    .win_last(win_last),
    .avg     (avg)
`ifdef DC_SETTLE_PKPK_EN
    ,
    .pkpk    (win_pkpk)
`endif
  );

  always_comb begin
    diff = DATA_W'(absdiff(32'(avg), 32'(prev_q)));
`ifdef DC_SETTLE_PKPK_EN
    ok = (diff <= DATA_W'(TOL)) && (win_pkpk <= DATA_W'(4 * TOL));
`else
    ok = (diff <= DATA_W'(TOL));
`endif
  end

  always_comb begin
    state_d   = state_q;
    settled_d = settled_q;
    timeout_d = timeout_q;
    result_d  = result_q;
    prev_d    = prev_q;
    wcnt_d    = wcnt_q;
    stable_d  = stable_q;
    first_d   = first_q;
    clear     = 1'b0;
    rdy       = 1'b0;
    fire      = 1'b0;
`ifdef DC_SETTLE_PKPK_EN
    pkpk_d    = pkpk_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ACQ;
          clear     = 1'b1;
          settled_d = 1'b0;
          timeout_d = 1'b0;
          wcnt_d    = '0;
          stable_d  = '0;
          first_d   = 1'b1;
        end
      end
      ACQ: begin
        rdy  = 1'b1;
        fire = s.s_valid;
        if (win_last) state_d = EVAL;
      end
      EVAL: begin
        clear    = 1'b1;
        result_d = avg;
        prev_d   = avg;
        wcnt_d   = wcnt_q + 1'b1;
        first_d  = 1'b0;
`ifdef DC_SETTLE_PKPK_EN
        pkpk_d   = win_pkpk;
`endif
        // The first window only seeds prev_avg; there is nothing to compare it to.
        if (!first_q) stable_d = ok ? (stable_q + 1'b1) : '0;
        if (stable_d == SB'(STABLE_N)) begin
          state_d   = DONE;
          settled_d = 1'b1;
        end else if (wcnt_d == WCNT_BITS'(MAX_WIN)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          state_d = ACQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      settled_q <= 1'b0;
      timeout_q <= 1'b0;
      result_q  <= '0;
      prev_q    <= '0;
      wcnt_q    <= '0;
      stable_q  <= '0;
      first_q   <= 1'b0;
`ifdef DC_SETTLE_PKPK_EN
      pkpk_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      settled_q <= settled_d;
      timeout_q <= timeout_d;
      result_q  <= result_d;
      prev_q    <= prev_d;
      wcnt_q    <= wcnt_d;
      stable_q  <= stable_d;
      first_q   <= first_d;
`ifdef DC_SETTLE_PKPK_EN
      pkpk_q    <= pkpk_d;
`endif
    end
  end

  assign s.s_ready = rdy;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign settled   = settled_q;
  assign timeout   = timeout_q;
  assign result    = result_q;
  assign win_count = wcnt_q;
`ifdef DC_SETTLE_PKPK_EN
  assign pkpk      = pkpk_q;
`endif

endmodule

// File: tb/tb_dc_settle_monitor.sv
// Self-checking bench for dc_settle_monitor; window averages and the settle rule are
// recomputed from accepted samples. Build with DC_SETTLE_PKPK_EN to cover ripple rejection.
module tb_dc_settle_monitor;

  localparam int unsigned NS   = 16;
  localparam int unsigned TOLV = 2;
  localparam int unsigned SN   = 2;
  localparam int unsigned MAXW = 64;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic        busy, done, settled, timeout;
  logic [11:0] result;
  logic [6:0]  win_count;
`ifdef DC_SETTLE_PKPK_EN
  logic [11:0] pkpk;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state
  int unsigned avgs[$];
  bit          oks[$];
  int unsigned win_sum, win_n, win_min, win_max, m_pk;
  bit          m_settled, m_timeout, m_end;

  dc_settle_monitor_if #(.DATA_W(12)) sif ();

  dc_settle_monitor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .s        (sif.slave),
    .busy     (busy),
    .done     (done),
    .settled  (settled),
    .timeout  (timeout),
    .result   (result),
    .win_count(win_count)
`ifdef DC_SETTLE_PKPK_EN
    ,
    .pkpk     (pkpk)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned gen(input int scn, input int unsigned idx);
    int unsigned tbl[4] = '{500, 510, 511, 512};
    case (scn)
      1:       return idx;
      2:       return tbl[(idx / NS) > 3 ? 3 : (idx / NS)];
      3:       return 2048;
      5:       return 1000 + $urandom_range(0, 4);
      6:       return (idx % 2) ? 1010 : 990;
      7:       return (idx % 2) ? 1001 : 999;
      8:       return 1000 + $urandom_range(0, 100);
      default: return 1000;
    endcase
  endfunction

  task automatic model_accept(input int unsigned v);
    if (win_n == 0) begin
      win_min = v;
      win_max = v;
    end else begin
      if (v < win_min) win_min = v;
      if (v > win_max) win_max = v;
    end
    win_sum += v;
    win_n++;
  endtask

  // Settled when the most recent SN window-to-window comparisons all passed.
  task automatic model_close();
    int unsigned a, d;
    bit ok, all_ok;
    a    = win_sum / NS;
    m_pk = win_max - win_min;
    if (avgs.size() > 0) begin
      d  = (a > avgs[$]) ? a - avgs[$] : avgs[$] - a;
      ok = (d <= TOLV);
`ifdef DC_SETTLE_PKPK_EN
      ok = ok && (m_pk <= 4 * TOLV);
`endif
      oks.push_back(ok);
    end
    avgs.push_back(a);
    all_ok = (oks.size() >= SN);
    for (int k = 0; k < int'(SN) && all_ok; k++)
      if (!oks[oks.size() - 1 - k]) all_ok = 0;
    m_settled = all_ok;
    m_timeout = !all_ok && (avgs.size() == MAXW);
    m_end     = m_settled || m_timeout;
    win_sum   = 0;
    win_n     = 0;
  endtask

  task automatic run(input int scn, input int unsigned gap_pct, input bit busy_start,
                     input bit done_start, input int unsigned abort_at);
    int unsigned idx = 0;
    int          phase = 0;
    bit          regchk = 0;
    bit          finished = 0;
    int unsigned cyc = 0;
    avgs.delete();
    oks.delete();
    win_sum = 0;
    win_n   = 0;
    m_end   = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_ready", sif.s_ready, 1);
    check("start_clr_wcnt", win_count, 0);
    check("start_clr_settled", settled, 0);
    check("start_clr_timeout", timeout, 0);
    while (!finished && cyc < 3000) begin
      cyc++;
      start = 1'b0;
      if (regchk) begin
        check("win_result", result, avgs[$]);
        check("win_count", win_count, avgs.size());
`ifdef DC_SETTLE_PKPK_EN
        check("win_pkpk", pkpk, m_pk);
`endif
        regchk = 0;
      end
      case (phase)
        1: begin
          check("eval_ready", sif.s_ready, 0);
          check("eval_done", done, 0);
          check("eval_busy", busy, 1);
          sif.s_valid = 1'($urandom_range(0, 1));
          phase  = m_end ? 2 : 0;
          regchk = 1;
        end
        2: begin
          check("done_pulse", done, 1);
          check("done_ready", sif.s_ready, 0);
          check("done_settled", settled, m_settled);
          check("done_timeout", timeout, m_timeout);
          sif.s_valid = 1'b0;
          if (done_start) start = 1'b1;
          finished = 1;
        end
        default: begin
          check("acq_ready", sif.s_ready, 1);
          check("acq_done", done, 0);
          if (abort_at != 0 && idx == abort_at) begin
            rst_n = 1'b0;
            sif.s_valid = 1'b1;
            @(negedge clk);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_ready", sif.s_ready, 0);
            check("rst_settled", settled, 0);
            check("rst_timeout", timeout, 0);
            check("rst_result", result, 0);
            check("rst_wcnt", win_count, 0);
            rst_n = 1'b1;
            sif.s_valid = 1'b0;
            @(negedge clk);
            check("rst_no_done", done, 0);
            return;
          end
          sif.s_valid = ($urandom_range(0, 99) >= gap_pct);
          if (busy_start && idx == 5) start = 1'b1;
          if (sif.s_valid) begin
            sif.s_data = 12'(gen(scn, idx));
            model_accept(sif.s_data);
            idx++;
            if (win_n == NS) begin
              model_close();
              phase = 1;
            end
          end
        end
      endcase
      @(negedge clk);
    end
    check("run_within_budget", finished, 1);
    start = 1'b0;
    check("post_done_low", done, 0);
    check("post_idle", busy, 0);
    check("post_ready", sif.s_ready, 0);
    check("post_hold_result", result, avgs[$]);
    check("post_hold_wcnt", win_count, avgs.size());
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ready", sif.s_ready, 0);
    check("reset_result", result, 0);
    check("reset_wcnt", win_count, 0);
    rst_n = 1'b1;
    sif.s_valid = 1'b1;
    @(negedge clk);
    check("idle_ignores_samples", sif.s_ready, 0);
    sif.s_valid = 1'b0;

    run(0, 0, 0, 0, 0);
    check("const_settled", settled, 1);
    check("const_result", result, 1000);
    check("const_wcnt", win_count, 3);

    run(1, 0, 0, 0, 0);
    check("ramp_timeout", timeout, 1);
    check("ramp_settled", settled, 0);
    check("ramp_wcnt", win_count, 64);
    check("ramp_result", result, 1015);

    run(2, 0, 1, 0, 0);
    check("step_settled", settled, 1);
    check("step_result", result, 512);
    check("step_wcnt", win_count, 4);

    run(3, 50, 0, 1, 0);
    check("gaps_result", result, 2048);
    check("gaps_wcnt", win_count, 3);

    run(0, 0, 0, 0, 20);
    run(0, 0, 0, 0, 0);
    check("rerun_settled", settled, 1);
    check("rerun_result", result, 1000);
    check("rerun_wcnt", win_count, 3);

    run(5, 30, 0, 0, 0);
    run(8, 30, 0, 0, 0);

`ifdef DC_SETTLE_PKPK_EN
    run(6, 0, 0, 0, 0);
    check("ripple_timeout", timeout, 1);
    check("ripple_pkpk", pkpk, 20);
    run(7, 0, 0, 0, 0);
    check("small_ripple_settled", settled, 1);
    check("small_ripple_wcnt", win_count, 3);
    check("small_ripple_pkpk", pkpk, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
